// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the IF/MEM SRAM port arbiter
package mem_arb_pkg;

   // Arbiter sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } state_t;

   // Largest supported SRAM latency and the timer width that holds LAT-1
   localparam int LAT_MAX = 15;
   localparam int CNT_W   = 4;

endpackage

// File: rtl/access_timer.sv
// rtl/access_timer.sv - loadable down-counter timing one SRAM access
module access_timer
   import mem_arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt,
   output logic             done
);

   // Load at access start, then count down and park at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM single-port SRAM arbiter, MEM priority; MEM_ARB_STATS_EN adds stall/access counters
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
`ifdef MEM_ARB_STATS_EN
   output logic [31:0] stat_if_stall,
   output logic [31:0] stat_data_acc,
`endif
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        flush,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   output logic        if_stall,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_ack,
   output logic [31:0] mem_rdata,
   output logic        freeze,
   output logic        sram_en,
   output logic        sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   // Out-of-range LAT values are clamped so the timer load always fits
   localparam int LAT_C = (LAT < 1) ? 1 : ((LAT > LAT_MAX) ? LAT_MAX : LAT);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LAT_C - 1);

   state_t           state;
   logic             kill;
   logic [CNT_W-1:0] cnt;
   logic             tmr_done;
   logic             idle_ok;
   logic             start_data;
   logic             start_fetch;

   // An ack cycle is a turnaround: the requester has not yet dropped its old request
   assign idle_ok     = (state == IDLE) & ~if_ack & ~mem_ack;
   assign start_data  = idle_ok & mem_req;
   assign start_fetch = idle_ok & ~mem_req & if_req & ~flush;

   // Stall outputs go quiet while reset is held so the pipeline sees no stale stall
   assign if_stall = if_req & ~if_ack & ~rst;
   assign freeze   = mem_req & ~mem_ack & ~rst;

   access_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (start_data | start_fetch),
      .load_val (LOAD_VAL),
      .cnt      (cnt),
      .done     (tmr_done)
   );

   // Arbitration FSM with registered SRAM controls, read data and ack pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         kill       <= 1'b0;
         sram_en    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         if_ack     <= 1'b0;
         mem_ack    <= 1'b0;
         if_rdata   <= '0;
         mem_rdata  <= '0;
      end else begin
         if_ack  <= 1'b0;
         mem_ack <= 1'b0;
         case (state)
            IDLE: begin
               kill <= 1'b0;
               if (start_data) begin
                  state      <= DATA;
                  sram_en    <= 1'b1;
                  sram_we    <= mem_we;
                  sram_addr  <= mem_addr;
                  sram_wdata <= mem_wdata;
               end else if (start_fetch) begin
                  state     <= FETCH;
                  sram_en   <= 1'b1;
                  sram_we   <= 1'b0;
                  sram_addr <= if_addr;
               end
            end
            FETCH: begin
               if (flush) begin
                  kill <= 1'b1;
               end
               if (tmr_done) begin
                  // A flushed fetch still finishes on the SRAM but is not acknowledged
                  if_rdata <= sram_rdata;
                  if_ack   <= ~(kill | flush);
                  kill     <= 1'b0;
                  sram_en  <= 1'b0;
                  state    <= IDLE;
               end
            end
            DATA: begin
               if (tmr_done) begin
                  if (!sram_we) begin
                     mem_rdata <= sram_rdata;
                  end
                  mem_ack <= 1'b1;
                  sram_en <= 1'b0;
                  sram_we <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_ARB_STATS_EN
   // Saturating IF-stall cycle count and completed DATA access count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_if_stall <= '0;
         stat_data_acc <= '0;
      end else begin
         if (if_stall && (stat_if_stall != '1)) begin
            stat_if_stall <= stat_if_stall + 32'd1;
         end
         if (mem_ack) begin
            stat_data_acc <= stat_data_acc + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter (LAT=2 and LAT=1 instances)
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   // LAT=2 instance
   logic        if_req = 0, flush = 0, mem_req = 0, mem_we = 0;
   logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0;
   logic        if_ack, if_stall, mem_ack, freeze, sram_en, sram_we;
   logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata, sram_rdata;
`ifdef MEM_ARB_STATS_EN
   logic [31:0] stat_if_stall, stat_data_acc, b_stat_if_stall, b_stat_data_acc;
`endif

   // LAT=1 instance
   logic        b_if_req = 0, b_flush = 0, b_mem_req = 0, b_mem_we = 0;
   logic [31:0] b_if_addr = 0, b_mem_addr = 0, b_mem_wdata = 0;
   logic        b_if_ack, b_if_stall, b_mem_ack, b_freeze, b_sram_en, b_sram_we;
   logic [31:0] b_if_rdata, b_mem_rdata, b_sram_addr, b_sram_wdata, b_sram_rdata;

   mem_port_arbiter #(.LAT(2)) dut (
      .clk(clk), .rst(rst),
`ifdef MEM_ARB_STATS_EN
      .stat_if_stall(stat_if_stall), .stat_data_acc(stat_data_acc),
`endif
      .if_req(if_req), .if_addr(if_addr), .flush(flush), .if_ack(if_ack), .if_rdata(if_rdata),
      .if_stall(if_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .freeze(freeze),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   mem_port_arbiter #(.LAT(1)) dut_b (
      .clk(clk), .rst(rst),
`ifdef MEM_ARB_STATS_EN
      .stat_if_stall(b_stat_if_stall), .stat_data_acc(b_stat_data_acc),
`endif
      .if_req(b_if_req), .if_addr(b_if_addr), .flush(b_flush), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
      .if_stall(b_if_stall), .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata), .freeze(b_freeze),
      .sram_en(b_sram_en), .sram_we(b_sram_we), .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata),
      .sram_rdata(b_sram_rdata)
   );

   // SRAM model contents
   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h10:  rom = 32'hDEADBEEF;
         32'h20:  rom = 32'h5555AAAA;
         32'h40:  rom = 32'h00001234;
         default: rom = a ^ 32'h0000FFFF;
      endcase
   endfunction

   // LAT=2 SRAM: data valid only once en/addr have been stable for LAT cycles
   int          en_cyc = 0;
   logic [31:0] last_addr = 0;
   always @(posedge clk) begin
      last_addr <= sram_addr;
      if (!sram_en)                    en_cyc <= 0;
      else if (sram_addr == last_addr) en_cyc <= en_cyc + 1;
      else                             en_cyc <= 1;
   end
   assign sram_rdata   = (sram_en && en_cyc >= 1) ? rom(sram_addr) : 32'hBAD0BAD0;
   assign b_sram_rdata = b_sram_en ? (b_sram_addr ^ 32'hA5A50000) : 32'hBAD0BAD0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      checks++; if ({sram_en, sram_we, if_ack, mem_ack, if_stall, freeze} !== 6'b0) begin errors++; $display("FAIL reset_ctl got=%b exp=000000", {sram_en, sram_we, if_ack, mem_ack, if_stall, freeze}); end
      checks++; if ((sram_addr | sram_wdata | if_rdata | mem_rdata) !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", sram_addr | sram_wdata | if_rdata | mem_rdata); end
      checks++; if ({b_sram_en, b_if_ack, b_mem_ack} !== 3'b0) begin errors++; $display("FAIL reset_b got=%b exp=000", {b_sram_en, b_if_ack, b_mem_ack}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fetch();
      if_req = 1; if_addr = 32'h10; #1;
      checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall0 got=%b exp=1", if_stall); end
      for (int c = 1; c <= 4; c++) begin
         tick();
         checks++; if (sram_en !== (c <= 2)) begin errors++; $display("FAIL fetch_en c%0d got=%b exp=%b", c, sram_en, (c <= 2)); end
         checks++; if (if_ack !== (c == 3)) begin errors++; $display("FAIL fetch_ack c%0d got=%b exp=%b", c, if_ack, (c == 3)); end
         checks++; if (if_stall !== (c < 3)) begin errors++; $display("FAIL fetch_stall c%0d got=%b exp=%b", c, if_stall, (c < 3)); end
         if (c <= 2) begin
            checks++; if ({sram_we, sram_addr} !== {1'b0, 32'h10}) begin errors++; $display("FAIL fetch_addr c%0d got=%h exp=10", c, sram_addr); end
         end
         if (c == 3) begin
            checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata got=%h exp=deadbeef", if_rdata); end
            if_req = 0;
         end
      end
   endtask

   task automatic test_priority();
      mem_req = 1; mem_we = 0; mem_addr = 32'h40; if_req = 1; if_addr = 32'h20; #1;
      checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL prio_freeze0 got=%b exp=1", freeze); end
      for (int c = 1; c <= 8; c++) begin
         tick();
         checks++; if (sram_en !== (c == 1 || c == 2 || c == 5 || c == 6)) begin errors++; $display("FAIL prio_en c%0d got=%b", c, sram_en); end
         checks++; if (mem_ack !== (c == 3)) begin errors++; $display("FAIL prio_mem_ack c%0d got=%b exp=%b", c, mem_ack, (c == 3)); end
         checks++; if (if_ack !== (c == 7)) begin errors++; $display("FAIL prio_if_ack c%0d got=%b exp=%b", c, if_ack, (c == 7)); end
         checks++; if (freeze !== (c <= 2)) begin errors++; $display("FAIL prio_freeze c%0d got=%b exp=%b", c, freeze, (c <= 2)); end
         if (c <= 2) begin
            checks++; if (sram_addr !== 32'h40) begin errors++; $display("FAIL prio_daddr c%0d got=%h exp=40", c, sram_addr); end
         end
         if (c == 5 || c == 6) begin
            checks++; if (sram_addr !== 32'h20) begin errors++; $display("FAIL prio_iaddr c%0d got=%h exp=20", c, sram_addr); end
         end
         if (c == 3) begin
            checks++; if (mem_rdata !== 32'h1234) begin errors++; $display("FAIL prio_mrdata got=%h exp=1234", mem_rdata); end
            mem_req = 0;
         end
         if (c == 7) begin
            checks++; if (if_rdata !== 32'h5555AAAA) begin errors++; $display("FAIL prio_irdata got=%h exp=5555aaaa", if_rdata); end
            if_req = 0;
         end
      end
   endtask

   task automatic test_store();
      mem_req = 1; mem_we = 1; mem_addr = 32'h80; mem_wdata = 32'hCAFEF00D;
      for (int c = 1; c <= 4; c++) begin
         tick();
         checks++; if ({sram_en, sram_we} !== {2{c <= 2}}) begin errors++; $display("FAIL store_en_we c%0d got=%b%b", c, sram_en, sram_we); end
         checks++; if ({mem_ack, if_ack} !== {c == 3, 1'b0}) begin errors++; $display("FAIL store_ack c%0d got=%b%b", c, mem_ack, if_ack); end
         if (c <= 2) begin
            checks++; if ({sram_addr, sram_wdata} !== {32'h80, 32'hCAFEF00D}) begin errors++; $display("FAIL store_bus c%0d got=%h/%h exp=80/cafef00d", c, sram_addr, sram_wdata); end
         end
         if (c == 3) begin
            mem_req = 0; mem_we = 0;
         end
      end
   endtask

   task automatic test_flush();
      if_req = 1; if_addr = 32'h10;
      for (int c = 1; c <= 10; c++) begin
         tick();
         checks++; if (sram_en !== (c == 1 || c == 2 || c == 4 || c == 5 || c == 7 || c == 8)) begin errors++; $display("FAIL flush_en c%0d got=%b", c, sram_en); end
         checks++; if (if_ack !== (c == 9)) begin errors++; $display("FAIL flush_ack c%0d got=%b exp=%b", c, if_ack, (c == 9)); end
         if (c == 2) begin
            checks++; if (sram_addr !== 32'h10) begin errors++; $display("FAIL flush_stable got=%h exp=10", sram_addr); end
         end
         if (c == 3) begin
            checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL flush_rdata_kill got=%h exp=deadbeef", if_rdata); end
         end
         if (c == 4 || c == 7) begin
            checks++; if (sram_addr !== 32'h20) begin errors++; $display("FAIL flush_newaddr c%0d got=%h exp=20", c, sram_addr); end
         end
         if (c == 9) begin
            checks++; if (if_rdata !== 32'h5555AAAA) begin errors++; $display("FAIL flush_rdata_new got=%h exp=5555aaaa", if_rdata); end
            if_req = 0;
         end
         if (c == 1) begin flush = 1; if_addr = 32'h20; end
         if (c == 2 || c == 6) flush = 0;
         if (c == 5) flush = 1;
      end
   endtask

   task automatic test_reset_mid();
      mem_req = 1; mem_we = 0; mem_addr = 32'h40;
      tick();
      tick();
      checks++; if (sram_en !== 1'b1) begin errors++; $display("FAIL rmid_pre_en got=%b exp=1", sram_en); end
      rst = 1; #1;
      checks++; if ({sram_en, sram_we, freeze, mem_ack, if_ack} !== 5'b0) begin errors++; $display("FAIL rmid_drop got=%b exp=00000", {sram_en, sram_we, freeze, mem_ack, if_ack}); end
      tick();
      rst = 0;
      for (int c = 1; c <= 3; c++) begin
         tick();
         checks++; if ({sram_en, mem_ack} !== {c <= 2, c == 3}) begin errors++; $display("FAIL rmid_after c%0d got=%b%b", c, sram_en, mem_ack); end
         if (c == 3) begin
            checks++; if (mem_rdata !== 32'h1234) begin errors++; $display("FAIL rmid_rdata got=%h exp=1234", mem_rdata); end
            mem_req = 0;
         end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int acks = 0;
      b_if_req = 1; b_if_addr = 32'h100;
      for (int c = 1; c <= 12; c++) begin
         tick();
         checks++; if (b_if_ack !== (c % 3 == 2)) begin errors++; $display("FAIL b2b_ack c%0d got=%b exp=%b", c, b_if_ack, (c % 3 == 2)); end
         if (b_if_ack) begin
            acks++;
            checks++; if (b_if_rdata !== (b_if_addr ^ 32'hA5A50000)) begin errors++; $display("FAIL b2b_rdata c%0d got=%h exp=%h", c, b_if_rdata, b_if_addr ^ 32'hA5A50000); end
            b_if_addr = b_if_addr + 32'd4;
         end
      end
      b_if_req = 0;
      checks++; if (acks != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", acks); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fetch();
      tick();
      test_priority();
      tick();
      test_store();
      tick();
      test_flush();
      tick();
      test_reset_mid();
      test_back_to_back();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
